collision_scheduler: RTL and testbench

//  Once per frame, tests puck-vs-paddle contact for both paddles and puck-vs-rail contact.

---
 rtl/collision_scheduler.sv | 173 +++++++++++++++++
 tb/tb_collision_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// Once-per-frame puck/paddle contact and puck/rail test, sharing a single 10x10 squarer
// across both paddles in a fixed eight-state sequence.
module collision_scheduler #(
    parameter int unsigned HIT_R2 = 625,
    parameter int unsigned PUCK_R = 10,
    parameter int unsigned X_MIN  = 224,
    parameter int unsigned X_MAX  = 704,
    parameter int unsigned Y_MIN  = 101,
    parameter int unsigned Y_MAX  = 441
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic [9:0] puck_x,
    input  logic [9:0] puck_y,
    input  logic [9:0] dot_x_1,
    input  logic [9:0] dot_y_1,
    input  logic [9:0] dot_x_2,
    input  logic [9:0] dot_y_2,
    output logic       busy,
    output logic       done,
    output logic       hit_1,
    output logic       hit_2,
    output logic       wall_l,
    output logic       wall_r,
    output logic       wall_t,
    output logic       wall_b,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE,
        P1X,
        P1Y,
        P1C,
        P2X,
        P2Y,
        P2C,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic   start;

    logic [9:0]  snap_px, snap_py, snap_x1, snap_y1, snap_x2, snap_y2;
    logic        sh_wl, sh_wr, sh_wt, sh_wb;
    logic        h1, h2;
    logic [20:0] acc;

    logic [9:0]  op_a, op_b, mag;
    logic [19:0] sq;
    logic        acc_lt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    start   = 1'b1;
                    state_d = P1X;
                end
            end
            P1X:     state_d = P1Y;
            P1Y:     state_d = P1C;
            P1C:     state_d = P2X;
            P2X:     state_d = P2Y;
            P2Y:     state_d = P2C;
            P2C:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand mux: the squarer only sees real operands in the P*X / P*Y states.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            P1X: begin op_a = snap_px; op_b = snap_x1; end
            P1Y: begin op_a = snap_py; op_b = snap_y1; end
            P2X: begin op_a = snap_px; op_b = snap_x2; end
            P2Y: begin op_a = snap_py; op_b = snap_y2; end
            default: begin op_a = '0; op_b = '0; end
        endcase
    end

    assign mag    = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
    assign sq     = 20'(mag) * 20'(mag);
    assign acc_lt = (acc < 21'(HIT_R2));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            snap_px <= '0;
            snap_py <= '0;
            snap_x1 <= '0;
            snap_y1 <= '0;
            snap_x2 <= '0;
            snap_y2 <= '0;
            sh_wl   <= 1'b0;
            sh_wr   <= 1'b0;
            sh_wt   <= 1'b0;
            sh_wb   <= 1'b0;
        end else if (start) begin
            snap_px <= puck_x;
            snap_py <= puck_y;
            snap_x1 <= dot_x_1;
            snap_y1 <= dot_y_1;
            snap_x2 <= dot_x_2;
            snap_y2 <= dot_y_2;
            sh_wl   <= (11'(puck_x) <= 11'(X_MIN + PUCK_R));
            sh_wr   <= (11'(puck_x) + 11'(PUCK_R) >= 11'(X_MAX));
            sh_wt   <= (11'(puck_y) <= 11'(Y_MIN + PUCK_R));
            sh_wb   <= (11'(puck_y) + 11'(PUCK_R) >= 11'(Y_MAX));
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc <= '0;
            h1  <= 1'b0;
            h2  <= 1'b0;
        end else begin
            case (state_q)
                P1X, P2X: acc <= 21'(sq);
                P1Y, P2Y: acc <= acc + 21'(sq);
                P1C:      h1  <= acc_lt;
                P2C:      h2  <= acc_lt;
                default:  acc <= acc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hit_1  <= 1'b0;
            hit_2  <= 1'b0;
            wall_l <= 1'b0;
            wall_r <= 1'b0;
            wall_t <= 1'b0;
            wall_b <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (state_q == DONE);
            if (state_q == DONE) begin
                hit_1  <= h1;
                hit_2  <= h2;
                wall_l <= sh_wl;
                wall_r <= sh_wr;
                wall_t <= sh_wt;
                wall_b <= sh_wb;
            end
        end
    end

    // busy falls with done; a tick taken on that same edge keeps it high.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (start)     busy <= 1'b1;
            else if (done) busy <= 1'b0;
            if (frame_tick && (state_q != IDLE)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: a geometric reference model predicts each pass,
// a negedge monitor checks every done pulse against the queued prediction.
module tb_collision_scheduler;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       frame_tick = 1'b0;
    logic [9:0] puck_x = '0, puck_y = '0;
    logic [9:0] dot_x_1 = '0, dot_y_1 = '0, dot_x_2 = '0, dot_y_2 = '0;
    logic       busy, done, hit_1, hit_2, wall_l, wall_r, wall_t, wall_b, overrun;

    collision_scheduler dut (
        .clk(clk), .clr(clr), .frame_tick(frame_tick),
        .puck_x(puck_x), .puck_y(puck_y),
        .dot_x_1(dot_x_1), .dot_y_1(dot_y_1), .dot_x_2(dot_x_2), .dot_y_2(dot_y_2),
        .busy(busy), .done(done), .hit_1(hit_1), .hit_2(hit_2),
        .wall_l(wall_l), .wall_r(wall_r), .wall_t(wall_t), .wall_b(wall_b),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit h1, h2, wl, wr, wt, wb;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, act, req);
        end
    endtask

    function automatic exp_t model(input int px, py, x1, y1, x2, y2, input int done_cyc);
        exp_t e;
        int d1, d2;
        d1 = (px - x1) * (px - x1) + (py - y1) * (py - y1);
        d2 = (px - x2) * (px - x2) + (py - y2) * (py - y2);
        e.cyc = done_cyc;
        e.h1  = (d1 < 625);
        e.h2  = (d2 < 625);
        e.wl  = (px <= 224 + 10);
        e.wr  = (px + 10 >= 704);
        e.wt  = (py <= 101 + 10);
        e.wb  = (py + 10 >= 441);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest prediction, on its predicted cycle.
    always @(negedge clk) begin
        if (!clr && done) begin
            exp_t e;
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", busy, 1);
                check("hit_1", hit_1, e.h1);
                check("hit_2", hit_2, e.h2);
                check("wall_l", wall_l, e.wl);
                check("wall_r", wall_r, e.wr);
                check("wall_t", wall_t, e.wt);
                check("wall_b", wall_b, e.wb);
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives a tick on the next negedge; returns at the negedge after edge N (cyc == N).
    task automatic tick_pass(input int px, py, x1, y1, x2, y2, input bit push);
        @(negedge clk);
        puck_x  = 10'(px); puck_y  = 10'(py);
        dot_x_1 = 10'(x1); dot_y_1 = 10'(y1);
        dot_x_2 = 10'(x2); dot_y_2 = 10'(y2);
        frame_tick = 1'b1;
        if (push) exp_q.push_back(model(px, py, x1, y1, x2, y2, cyc + 1 + 7));
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    function automatic int offs(input int c, input int span);
        int v;
        v = c + int'($urandom_range(2 * span, 0)) - span;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    initial begin
        int n, px, py;

        // Reset state and idle behaviour
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {hit_1, hit_2, wall_l, wall_r, wall_t, wall_b}, 0);
        check("rst_overrun", overrun, 0);
        repeat (100) @(negedge clk);
        check("idle_no_done", done_seen, 0);

        // Basic hit/miss with busy window
        tick_pass(400, 300, 420, 300, 600, 300, 1);
        n = cyc;
        for (int i = 0; i < 8; i++) begin
            check("busy_window", busy, 1);
            @(negedge clk);
        end
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("flags_hold", {hit_1, hit_2, wall_l, wall_r, wall_t, wall_b}, 6'b100000);

        // Distance boundaries
        tick_pass(400, 300, 425, 300, 600, 300, 1); wait_to(cyc + 8);
        tick_pass(400, 300, 415, 320, 600, 300, 1); wait_to(cyc + 8);
        tick_pass(400, 300, 424, 300, 400, 276, 1); wait_to(cyc + 8);
        tick_pass(400, 300, 380, 300, 400, 325, 1); wait_to(cyc + 8);

        // Randomized passes, back-to-back or with small gaps, inputs scrambled mid-pass
        for (int k = 0; k < 40; k++) begin
            px = int'($urandom_range(780, 150));
            py = int'($urandom_range(480, 60));
            tick_pass(px, py, offs(px, 30), offs(py, 30),
                      offs(px, ($urandom_range(1, 0) == 1) ? 30 : 300), offs(py, 30), 1);
            n = cyc;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                puck_x  = 10'($urandom); puck_y  = 10'($urandom);
                dot_x_1 = 10'($urandom); dot_y_1 = 10'($urandom);
                dot_x_2 = 10'($urandom); dot_y_2 = 10'($urandom);
            end
            wait_to(n + 6 + int'($urandom_range(3, 0)));
        end
        wait_to(cyc + 10);
        check("no_overrun_at_rate", overrun, 0);

        // Overrun: ticks at N+3 and N+7 ignored, N+9 starts a new pass
        tick_pass(400, 300, 410, 300, 600, 300, 1);
        n = cyc;
        wait_to(n + 1);
        tick_pass(500, 200, 500, 200, 500, 200, 0);
        check("overrun_set", overrun, 1);
        wait_to(n + 5);
        tick_pass(500, 200, 500, 200, 500, 200, 0);
        tick_pass(400, 300, 410, 300, 395, 310, 1);
        check("overrun_sticky", overrun, 1);
        wait_to(n + 18);
        check("overrun_single_done", done_seen, 47);

        // Reset mid-pass clears everything at once and suppresses done
        tick_pass(300, 200, 700, 400, 600, 300, 1);
        n = cyc;
        wait_to(n + 3);
        clr = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_flags", {hit_1, hit_2, wall_l, wall_r, wall_t, wall_b}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        wait_to(n + 12);
        check("midrst_no_done", done_seen, 47);
        tick_pass(600, 350, 590, 340, 100, 100, 1);
        wait_to(cyc + 8);

        // Walls and snapshot isolation
        tick_pass(234, 431, 300, 300, 600, 300, 1);
        n = cyc;
        @(negedge clk);
        dot_x_1 = 10'd234;
        dot_y_1 = 10'd431;
        wait_to(n + 7);
        check("iso_done", done, 1);
        check("iso_hit_1", hit_1, 0);
        check("iso_wall_lb", {wall_l, wall_r, wall_t, wall_b}, 4'b1001);

        wait_to(cyc + 12);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
